// File: rtl/decode_pkg.sv
// Shared decode constants, control/bundle types and the opcode/funct decoder.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package decode_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_SLL = 6'b000000;

   localparam logic [4:0] REG_LINK = 5'd31;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_SLL = 3'd3,
      ALU_NOP = 3'd7
   } alu_op_e;

   typedef struct packed {
      alu_op_e    alu_op;
      logic [4:0] dest;
      logic       reg_write;
      logic       mem_read;
      logic       jump;
      logic       link;
      logic       illegal;
   } ctrl_t;

   typedef struct packed {
      ctrl_t           ctrl;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      shamt;
      logic [AW-1:0]   pc_plus1;
   } bundle_t;

   // Reset bundle: everything zero except the ALU op, which idles at NOP (MSB field).
   localparam bundle_t BUNDLE_RST = bundle_t'({ALU_NOP, {($bits(bundle_t) - 3){1'b0}}});

   // Control decode. Only the fields an opcode actually uses feed the control
   // outputs, so junk in unused fields cannot leak into them.
   function automatic ctrl_t decode_ctrl(input logic [XLEN-1:0] instr);
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_NOP;
      case (instr[31:26])
         OP_RTYPE: begin
            case (instr[5:0])
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_SLL:  c.alu_op = ALU_SLL;
               default: c.illegal = 1'b1;
            endcase
            if (!c.illegal) begin
               c.dest      = instr[15:11];
               c.reg_write = 1'b1;
            end
         end
         OP_LW: begin
            c.alu_op    = ALU_ADD;
            c.mem_read  = 1'b1;
            c.dest      = instr[20:16];
            c.reg_write = 1'b1;
         end
         OP_J: begin
            c.jump = 1'b1;
         end
         OP_JAL: begin
            c.jump      = 1'b1;
            c.link      = 1'b1;
            c.dest      = REG_LINK;
            c.reg_write = 1'b1;
         end
         default: c.illegal = 1'b1;
      endcase
      if (c.dest == 5'd0) c.reg_write = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side, writeback and execute-side signals of the decode stage.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the fetch and execute sides.
interface instr_decode_stage_if;

   logic                          in_valid;
   logic                          in_ready;
   logic [decode_pkg::XLEN-1:0]   instr;
   logic [decode_pkg::AW-1:0]     in_pc;
   logic                          wb_en;
   logic [4:0]                    wb_addr;
   logic [decode_pkg::XLEN-1:0]   wb_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [2:0]                    out_alu_op;
   logic [decode_pkg::XLEN-1:0]   out_rs_data;
   logic [decode_pkg::XLEN-1:0]   out_rt_data;
   logic [decode_pkg::XLEN-1:0]   out_imm;
   logic [4:0]                    out_shamt;
   logic [4:0]                    out_dest;
   logic                          out_reg_write;
   logic                          out_mem_read;
   logic                          out_jump;
   logic                          out_link;
   logic [decode_pkg::AW-1:0]     out_pc_plus1;
   logic                          out_illegal;
   logic                          redirect_valid;
   logic [decode_pkg::AW-1:0]     redirect_pc;

   modport master (
      output in_valid, instr, in_pc, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, out_alu_op, out_rs_data, out_rt_data, out_imm,
             out_shamt, out_dest, out_reg_write, out_mem_read, out_jump, out_link,
             out_pc_plus1, out_illegal, redirect_valid, redirect_pc
   );

   modport slave (
      input  in_valid, instr, in_pc, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, out_alu_op, out_rs_data, out_rt_data, out_imm,
             out_shamt, out_dest, out_reg_write, out_mem_read, out_jump, out_link,
             out_pc_plus1, out_illegal, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/decode_regfile.sv
// 32x32 register file, one write port, two read ports; r0 is hardwired zero.
// Latency: reads combinational with same-cycle write bypass; writes land at posedge.
// Backpressure: none.
module decode_regfile
   import decode_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      rs_addr,
   input  logic [4:0]      rt_addr,
   output logic [XLEN-1:0] rs_data,
   output logic [XLEN-1:0] rt_data
);

   logic [XLEN-1:0] regs [NREG];

   // Storage: synchronous clear, writes to r0 dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_en && (wb_addr != 5'd0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Read ports: r0 is zero, an in-flight write to the same register wins.
   always_comb begin
      rs_data = regs[rs_addr];
      rt_data = regs[rt_addr];
      if (rs_addr == 5'd0)                     rs_data = '0;
      else if (wb_en && (wb_addr == rs_addr))  rs_data = wb_data;
      if (rt_addr == 5'd0)                     rt_data = '0;
      else if (wb_en && (wb_addr == rt_addr))  rt_data = wb_data;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field split, regfile read, registered bundle to execute, jump redirect.
// Latency: 1 cycle from accept to out_valid; redirect pulses the cycle after a jump is accepted.
// Backpressure: in_ready = !out_valid | out_ready; the bundle holds while execute stalls.
module instr_decode_stage
   import decode_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   instr_decode_stage_if.slave io
);

   logic            in_ready;
   logic            accept;
   logic [XLEN-1:0] rs_rdata;
   logic [XLEN-1:0] rt_rdata;
   ctrl_t           ctrl_d;
   bundle_t         bundle_d;
   bundle_t         bundle_q;
   logic            out_valid_q;
   logic            redirect_valid_q;
   logic [AW-1:0]   redirect_pc_q;
   logic            squash_q;

   decode_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .wb_en   (io.wb_en),
      .wb_addr (io.wb_addr),
      .wb_data (io.wb_data),
      .rs_addr (io.instr[25:21]),
      .rt_addr (io.instr[20:16]),
      .rs_data (rs_rdata),
      .rt_data (rt_rdata)
   );

   assign in_ready = !out_valid_q || io.out_ready;
   assign accept   = io.in_valid && in_ready;

   // Build the next bundle from the presented word.
   always_comb begin
      ctrl_d            = decode_ctrl(io.instr);
      bundle_d          = BUNDLE_RST;
      bundle_d.ctrl     = ctrl_d;
      bundle_d.rs_data  = rs_rdata;
      bundle_d.rt_data  = rt_rdata;
      bundle_d.imm      = {{(XLEN - 16){io.instr[15]}}, io.instr[15:0]};
      bundle_d.shamt    = io.instr[10:6];
      bundle_d.pc_plus1 = io.in_pc + AW'(1);
   end

   // Output register, redirect pulse and the single-word squash after a jump.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q      <= 1'b0;
         bundle_q         <= BUNDLE_RST;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         squash_q         <= 1'b0;
      end else begin
         redirect_valid_q <= 1'b0;
         if (accept) begin
            if (squash_q) begin
               // Wrong-path word behind a jump: swallow it.
               squash_q    <= 1'b0;
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q <= 1'b1;
               bundle_q    <= bundle_d;
               if (ctrl_d.jump) begin
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= io.instr[AW-1:0];
                  squash_q         <= 1'b1;
               end
            end
         end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign io.in_ready       = in_ready;
   assign io.out_valid      = out_valid_q;
   assign io.out_alu_op     = bundle_q.ctrl.alu_op;
   assign io.out_rs_data    = bundle_q.rs_data;
   assign io.out_rt_data    = bundle_q.rt_data;
   assign io.out_imm        = bundle_q.imm;
   assign io.out_shamt      = bundle_q.shamt;
   assign io.out_dest       = bundle_q.ctrl.dest;
   assign io.out_reg_write  = bundle_q.ctrl.reg_write;
   assign io.out_mem_read   = bundle_q.ctrl.mem_read;
   assign io.out_jump       = bundle_q.ctrl.jump;
   assign io.out_link       = bundle_q.ctrl.link;
   assign io.out_pc_plus1   = bundle_q.pc_plus1;
   assign io.out_illegal    = bundle_q.ctrl.illegal;
   assign io.redirect_valid = redirect_valid_q;
   assign io.redirect_pc    = redirect_pc_q;

endmodule
